// File: rtl/project_pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral: counting modes, direction
// encoding and the comparator's output action encodings.
package project_pwm_peripheral_pkg;

  localparam int unsigned MODE_WIDTH = 2;

  // Counting modes carried on i_mode
  localparam logic [MODE_WIDTH-1:0] MODE_STOP   = 2'b00;
  localparam logic [MODE_WIDTH-1:0] MODE_UP     = 2'b01;
  localparam logic [MODE_WIDTH-1:0] MODE_DOWN   = 2'b10;
  localparam logic [MODE_WIDTH-1:0] MODE_UPDOWN = 2'b11;

  // Count direction
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Output actions applied by the comparator on a match
  typedef enum logic [1:0] {
    ACT_NOTHING = 2'd0,
    ACT_CLEAR   = 2'd1,
    ACT_SET     = 2'd2,
    ACT_TOGGLE  = 2'd3
  } action_e;

endpackage

// File: rtl/project_pwm_peripheral_prescaler.sv
// Prescaler tick decode for the PWM time base.
// Ports:
//   pcnt       - current prescaler count (held in the time base)
//   run        - time base is enabled in a counting mode
//   i_prescale - terminal prescaler value; a tick every i_prescale+1 clocks
//   o_tick     - combinational: this cycle's closing edge advances the counter
module project_pwm_peripheral_prescaler #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic [PRESCALE_WIDTH-1:0] pcnt,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);

  // >= so that lowering i_prescale below the running count still ticks
  assign o_tick = run && (pcnt >= i_prescale);

endmodule

// File: rtl/project_pwm_peripheral_timebase.sv
// Time-base counter for the PWM peripheral, feeding the comparator.
// Supports up, down and up-down counting, a prescaler and a period shadow
// that reloads only when the counter enters zero.
// Ports:
//   i_clk, i_reset   - clock and synchronous active-high reset
//   i_enable         - count enable; counter holds when low
//   i_mode           - STOP / UP / DOWN / UPDOWN
//   i_prescale       - counter advances every i_prescale+1 clocks
//   i_period         - shadow period, transferred at the zero boundary
//   i_clear          - synchronous restart of the time base
//   o_counter        - current count (registered)
//   o_counter_next   - value taken at the next tick (combinational)
//   o_period         - active period (registered)
//   o_tick           - combinational tick strobe
//   o_dir            - count direction, 1 = up (registered)
module project_pwm_peripheral_timebase
  import project_pwm_peripheral_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [1:0]                i_mode,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic [WIDTH-1:0]          i_period,
  input  logic                      i_clear,
  output logic [WIDTH-1:0]          o_counter,
  output logic [WIDTH-1:0]          o_counter_next,
  output logic [WIDTH-1:0]          o_period,
  output logic                      o_tick,
  output logic                      o_dir
);

  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic                      run;
  logic                      tick;
  logic [WIDTH-1:0]          cnt_next;
  logic                      dir_next;

  assign run = i_enable && (i_mode != MODE_STOP);

  // Prescaler tick decode
  project_pwm_peripheral_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .pcnt      (pcnt),
    .run       (run),
    .i_prescale(i_prescale),
    .o_tick    (tick)
  );

  assign o_tick         = tick;
  assign o_counter_next = cnt_next;

  // Next counter value and direction, shown continuously to the comparator
  always_comb begin
    cnt_next = o_counter;
    dir_next = o_dir;
    case (i_mode)
      MODE_UP: begin
        dir_next = DIR_UP;
        cnt_next = (o_counter >= o_period) ? '0 : o_counter + WIDTH'(1);
      end
      MODE_DOWN: begin
        dir_next = DIR_DOWN;
        cnt_next = ((o_counter == '0) || (o_counter > o_period)) ? o_period
                                                                  : o_counter - WIDTH'(1);
      end
      MODE_UPDOWN: begin
        if (o_dir == DIR_UP) begin
          if (o_counter >= o_period) begin
            // A zero period cannot turn around; stay parked at 0 counting up
            if (o_period == '0) begin
              cnt_next = '0;
              dir_next = DIR_UP;
            end else begin
              cnt_next = o_period - WIDTH'(1);
              dir_next = DIR_DOWN;
            end
          end else begin
            cnt_next = o_counter + WIDTH'(1);
          end
        end else begin
          if (o_counter == '0) begin
            cnt_next = (o_period == '0) ? '0 : WIDTH'(1);
            dir_next = DIR_UP;
          end else if (o_counter > o_period) begin
            cnt_next = o_period;
          end else begin
            cnt_next = o_counter - WIDTH'(1);
          end
        end
      end
      default: begin
        cnt_next = o_counter;
        dir_next = o_dir;
      end
    endcase
  end

  // Counter, prescaler, direction and period shadow state
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_counter <= '0;
      pcnt      <= '0;
      o_dir     <= DIR_UP;
      o_period  <= i_period;
    end else begin
      if (!run || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_WIDTH'(1);
      end
      if (tick) begin
        o_counter <= cnt_next;
        o_dir     <= dir_next;
        // Period only changes as the counter enters zero so it is never torn
        if (cnt_next == '0) begin
          o_period <= i_period;
        end
      end
    end
  end

endmodule
